div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_pkg.sv | 38 +++
 rtl/div_iter.sv | 188 ++++++++++++++++++
 tb/tb_div_iter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_pkg
// Description : Shared definitions for the iterative divider: FSM state
//               encodings, result-bus width, step-count constants and an
//               absolute-value helper used when latching signed operands.
// Revision    : 1.0 - initial release
// ============================================================================
package div_iter_pkg;

   // Operand width handled by the iteration datapath
   localparam int DIV_WIDTH     = 32;
   // {remainder, quotient} as packed onto the hi/lo write bus
   localparam int DIV_RESULT_WD = 64;
   // Counter value during the 32nd (final) shift-subtract step
   localparam logic [5:0] DIV_LAST_STEP = 6'd31;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BYZERO = 2'd1,
      ST_ON     = 2'd2,
      ST_END    = 2'd3
   } div_state_e;

   // Magnitude of a value; only treated as two's complement when signed.
   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   function automatic logic [DIV_WIDTH-1:0] div_abs(
      input logic [DIV_WIDTH-1:0] value,
      input logic                 is_signed
   );
      if (is_signed && value[DIV_WIDTH-1]) begin
         return (~value) + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      end
      return value;
   endfunction

endpackage : div_iter_pkg
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Multi-cycle restoring divider for the EX stage. Performs
//               signed (div) or unsigned (divu) 32-bit division, one
//               shift-subtract step per clock, and presents
//               {remainder, quotient} until the requester drops start_i.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start_i         - division request, held until ready_o
//               annul_i         - flush the in-flight division
//               signed_div_i    - 1 = signed, 0 = unsigned
//               opdata1_i       - dividend
//               opdata2_i       - divisor
//               result_o        - {remainder[63:32], quotient[31:0]}
//               ready_o         - result_o valid
//               stallreq_o      - pipeline stall request
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
   import div_iter_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   input  logic                     annul_i,
   input  logic                     signed_div_i,
   input  logic [WIDTH-1:0]         opdata1_i,
   input  logic [WIDTH-1:0]         opdata2_i,
   output logic [DIV_RESULT_WD-1:0] result_o,
   output logic                     ready_o,
   output logic                     stallreq_o
);

   div_state_e               state_q, state_d;
   logic [5:0]               cnt_q;
   logic [WIDTH-1:0]         rem_q;      // partial remainder
   logic [WIDTH-1:0]         quo_q;      // dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0]         dvsr_q;     // divisor magnitude
   logic                     quo_neg_q;  // operand signs differ on a signed divide
   logic                     rem_neg_q;  // negative dividend on a signed divide
   logic [DIV_RESULT_WD-1:0] result_q;

   logic                     w_accept;
   logic [WIDTH:0]           w_partial;
   logic                     w_ge;
   logic [WIDTH-1:0]         w_diff;
   logic [WIDTH-1:0]         w_rem_next;
   logic [WIDTH-1:0]         w_quo_next;
   logic [WIDTH-1:0]         w_quo_fix;
   logic [WIDTH-1:0]         w_rem_fix;

   assign w_accept = (state_q == ST_IDLE) && start_i && !annul_i;

   // ---------------------------------------------------------------------
   // One restoring step: bring down the next dividend bit and subtract the
   // divisor if it fits. The subtraction only needs WIDTH bits because the
   // result is kept only when it is smaller than the divisor.
   // ---------------------------------------------------------------------
   assign w_partial  = {rem_q, quo_q[WIDTH-1]};
   assign w_ge       = (w_partial >= {1'b0, dvsr_q});
   assign w_diff     = w_partial[WIDTH-1:0] - dvsr_q;
   assign w_rem_next = w_ge ? w_diff : w_partial[WIDTH-1:0];
   assign w_quo_next = {quo_q[WIDTH-2:0], w_ge};

   // Sign fix-up applied to the outcome of the final step
   assign w_quo_fix  = quo_neg_q ? (~w_quo_next + {{(WIDTH-1){1'b0}}, 1'b1}) : w_quo_next;
   assign w_rem_fix  = rem_neg_q ? (~w_rem_next + {{(WIDTH-1){1'b0}}, 1'b1}) : w_rem_next;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               state_d = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
            end
         end
         ST_BYZERO: begin
            state_d = annul_i ? ST_IDLE : ST_END;
         end
         ST_ON: begin
            if (annul_i) begin
               state_d = ST_IDLE;
            end else if (cnt_q == DIV_LAST_STEP) begin
               state_d = ST_END;
            end
         end
         ST_END: begin
            // Flush is ignored here; only the requester releasing start_i
            // frees the unit, so a held start_i cannot launch a new divide.
            if (!start_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      ready_o    = 1'b0;
      stallreq_o = 1'b0;
      result_o   = '0;
      case (state_q)
         ST_IDLE:   stallreq_o = start_i && !annul_i;
         ST_BYZERO: stallreq_o = 1'b1;
         ST_ON:     stallreq_o = 1'b1;
         ST_END: begin
            ready_o  = 1'b1;
            result_o = result_q;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= 6'd0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_q    <= 6'd0;
               result_q <= '0;
               if (w_accept) begin
                  rem_q     <= '0;
                  quo_q     <= div_abs(opdata1_i, signed_div_i);
                  dvsr_q    <= div_abs(opdata2_i, signed_div_i);
                  quo_neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  rem_neg_q <= signed_div_i && opdata1_i[WIDTH-1];
               end
            end
            ST_BYZERO: begin
               cnt_q    <= 6'd0;
               result_q <= '0;
            end
            ST_ON: begin
               if (annul_i) begin
                  cnt_q <= 6'd0;
               end else begin
                  rem_q <= w_rem_next;
                  quo_q <= w_quo_next;
                  if (cnt_q == DIV_LAST_STEP) begin
                     cnt_q    <= 6'd0;
                     result_q <= {w_rem_fix, w_quo_fix};
                  end else begin
                     cnt_q <= cnt_q + 6'd1;
                  end
               end
            end
            ST_END: begin
               if (!start_i) begin
                  result_q <= '0;
               end
            end
            default: cnt_q <= 6'd0;
         endcase
      end
   end

endmodule : div_iter
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter
// Description : Self-checking bench for div_iter. A vector table covers the
//               arithmetic and latency; directed sequences cover flush,
//               mid-division reset and start_i held past ready_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   int checks;
   int errors;

   div_iter #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stallreq_o   (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;   // {remainder, quotient}
      int          lat;   // clock edges from accept edge (inclusive) to ready_o
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Launch a division at the next falling edge, then wait for ready_o.
   // Returns the number of rising edges counted, including the accept edge.
   task automatic launch_and_wait(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  input string name, output int lat);
      int stall_gaps;
      bit seen;
      @(negedge clk);
      start_i      = 1'b1;
      annul_i      = 1'b0;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      #1;
      check({name, " stall cycle0"}, {63'd0, stallreq_o}, 64'd1);
      lat        = 0;
      seen       = 1'b0;
      stall_gaps = 0;
      while (!seen && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (ready_o) seen = 1'b1;
         else if (!stallreq_o) stall_gaps++;
      end
      check({name, " stall gaps"}, 64'(stall_gaps), 64'd0);
   endtask

   task automatic release_and_check(input string name);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check({name, " idle ready"}, {63'd0, ready_o}, 64'd0);
      check({name, " idle result"}, result_o, 64'd0);
   endtask

   initial begin
      int lat;
      logic [63:0] held;
      bit ready_seen;

      checks = 0;
      errors = 0;

      vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,          32'd14},         33};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF,  32'hFFFF_FFFD},  33};
      vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,{32'd0,          32'h8000_0000},  33};
      vecs[3] = '{1'b0, 32'd5,          32'd0,        64'd0,                            2};
      vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'h10,       {32'hF,          32'h0FFF_FFFF},  33};
      vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE,{32'd1,          32'hFFFF_FFFD},  33};
      vecs[6] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,{32'hFFFF_FFFF,  32'd3},          33};
      vecs[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,{32'h8000_0000,  32'd0},          33};
      vecs[8] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        64'd0,                            2};
      vecs[9] = '{1'b0, 32'd0,          32'd3,        64'd0,                            33};

      rst          = 1'b1;
      start_i      = 1'b0;
      annul_i      = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i    = '0;
      opdata2_i    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset ready", {63'd0, ready_o}, 64'd0);
      check("reset result", result_o, 64'd0);
      check("reset stall", {63'd0, stallreq_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < 10; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         launch_and_wait(vecs[i].sgn, vecs[i].a, vecs[i].b, nm, lat);
         check({nm, " latency"}, 64'(lat), 64'(vecs[i].lat));
         check({nm, " result"}, result_o, vecs[i].exp);
         check({nm, " stall in END"}, {63'd0, stallreq_o}, 64'd0);
         release_and_check(nm);
      end

      // ---------------- flush at step 10 ----------------
      @(negedge clk);
      start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
      ready_seen = 1'b0;
      repeat (11) begin
         @(posedge clk);
         #1;
         if (ready_o) ready_seen = 1'b1;
      end
      @(negedge clk);
      annul_i = 1'b1;          // start_i still high: a flushed IDLE must not accept
      @(posedge clk);
      #1;
      if (ready_o) ready_seen = 1'b1;
      check("annul ready", {63'd0, ready_o}, 64'd0);
      check("annul result", result_o, 64'd0);
      check("annul stall", {63'd0, stallreq_o}, 64'd0);
      @(posedge clk);
      #1;
      if (ready_o) ready_seen = 1'b1;
      check("annul no ready pulse", {63'd0, ready_seen}, 64'd0);
      @(negedge clk);
      annul_i = 1'b0;
      start_i = 1'b0;
      launch_and_wait(1'b0, 32'd100, 32'd7, "post-annul", lat);
      check("post-annul latency", 64'(lat), 64'd33);
      check("post-annul result", result_o, {32'd2, 32'd14});
      release_and_check("post-annul");

      // ---------------- reset at step 20 ----------------
      @(negedge clk);
      start_i = 1'b1; signed_div_i = 1'b1; opdata1_i = 32'd12345; opdata2_i = 32'd11;
      repeat (21) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      start_i = 1'b0;
      @(posedge clk);
      #1;
      check("midrst ready", {63'd0, ready_o}, 64'd0);
      check("midrst result", result_o, 64'd0);
      check("midrst stall", {63'd0, stallreq_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      ready_seen = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (ready_o) ready_seen = 1'b1;
      end
      check("midrst no ready pulse", {63'd0, ready_seen}, 64'd0);
      launch_and_wait(1'b0, 32'hFFFF_FFFF, 32'h10, "post-rst", lat);
      check("post-rst latency", 64'(lat), 64'd33);
      check("post-rst result", result_o, {32'hF, 32'h0FFF_FFFF});
      release_and_check("post-rst");

      // ---------------- start held past ready_o ----------------
      launch_and_wait(1'b1, 32'hFFFF_FFF9, 32'd2, "hold", lat);
      check("hold latency", 64'(lat), 64'd33);
      held = result_o;
      check("hold result", held, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         opdata1_i = 32'd50 + 32'(k);     // new operands must not start a divide
         opdata2_i = 32'(k);
         annul_i   = (k == 2);             // flush ignored in END
         @(posedge clk);
         #1;
         check($sformatf("hold%0d ready", k), {63'd0, ready_o}, 64'd1);
         check($sformatf("hold%0d result", k), result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
         check($sformatf("hold%0d stall", k), {63'd0, stallreq_o}, 64'd0);
      end
      @(negedge clk);
      annul_i = 1'b0;
      release_and_check("hold");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends on its own
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule : tb_div_iter
`default_nettype wire
